// File: rtl/shift_pkg.sv
// Shared encodings for the sequential left-shift unit: operation codes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_PASS = 2'b00,
        OP_LSL  = 2'b01,
        OP_ROL  = 2'b10,
        OP_RLC  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_SHIFT = 2'b01,
        S_DONE  = 2'b10
    } state_e;

endpackage

// File: rtl/shift_left_seq_if.sv
// Start/done request bus between the sequencer (master) and the shift unit (slave).
interface shift_left_seq_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [1:0]       op;
    logic [CNT_W-1:0] amount;
    logic             C_in;
    logic [WIDTH-1:0] Y;
    logic             C_out;
    logic             busy;
    logic             done;

    modport master (
        output start, A, op, amount, C_in,
        input  Y, C_out, busy, done
    );

    modport slave (
        input  start, A, op, amount, C_in,
        output Y, C_out, busy, done
    );
endinterface

// File: rtl/shift_left_step.sv
// One-position left step: LSL fills with zero, ROL recirculates the MSB,
// RLC rotates the (WIDTH+1)-bit value {carry, y}.
module shift_left_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] y,
    input  logic             c,
    input  op_e              op_r,
    output logic [WIDTH-1:0] y_next,
    output logic             c_next
);

    always_comb begin
        c_next = y[WIDTH-1];
        y_next = {y[WIDTH-2:0], 1'b0};
        case (op_r)
            OP_PASS: begin
                y_next = y;
                c_next = c;
            end
            OP_ROL:  y_next[0] = y[WIDTH-1];
            OP_RLC:  y_next[0] = c;
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_left_seq.sv
// Multi-cycle left shifter (LSL/ROL/RLC): one bit position per clock,
// run-time amount, start/done handshake with registered busy/done.
module shift_left_seq
    import shift_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    shift_left_seq_if.slave   bus
);

    state_e           state;
    op_e              op_r;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] y;
    logic             c;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] y_next;
    logic             c_next;

    shift_left_step #(.WIDTH(WIDTH)) u_step (
        .y      (y),
        .c      (c),
        .op_r   (op_r),
        .y_next (y_next),
        .c_next (c_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
            op_r  <= OP_PASS;
            cnt   <= '0;
            y     <= '0;
            c     <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (bus.start) begin
                        y    <= bus.A;
                        c    <= bus.C_in;
                        op_r <= op_e'(bus.op);
                        cnt  <= bus.amount;
                        busy <= 1'b1;
                        // Pass-through and zero-amount requests skip straight to reporting.
                        if (op_e'(bus.op) == OP_PASS || bus.amount == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    y   <= y_next;
                    c   <= c_next;
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Y     = y;
    assign bus.C_out = c;
    assign bus.busy  = busy;
    assign bus.done  = done;

endmodule

// File: tb/tb_shift_left_seq.sv
// Scoreboard bench for shift_left_seq: stimulus queues expected results from a
// rotate/shift arithmetic model, a negedge monitor checks them on each done pulse.
module tb_shift_left_seq;

    typedef struct {
        logic [15:0] y;
        logic        c;
        int          at;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t q[$];

    shift_left_seq_if #(.WIDTH(16), .CNT_W(4)) bus ();

    shift_left_seq #(.WIDTH(16), .CNT_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result of a k-position shift computed in one go; s is the cycle count
    // sampled on the negedge where start is presented.
    function automatic exp_t model(input logic [15:0] a, input logic [1:0] op,
                                   input int k, input logic cin, input int s);
        exp_t        e;
        logic [16:0] v;
        logic [16:0] r;
        e.y = a;
        e.c = cin;
        if (op != 2'b00 && k != 0) begin
            case (op)
                2'b01: begin
                    v   = {cin, a} << k;
                    e.y = v[15:0];
                    e.c = v[16];
                end
                2'b10: begin
                    e.y = (a << k) | (a >> (16 - k));
                    e.c = a[16 - k];
                end
                default: begin
                    v   = {cin, a};
                    r   = (v << k) | (v >> (17 - k));
                    e.y = r[15:0];
                    e.c = r[16];
                end
            endcase
        end
        e.at = s + ((op == 2'b00 || k == 0) ? 1 : k + 1);
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pending result", cyc);
            end else begin
                e = q.pop_front();
                check("Y", 32'(bus.Y), 32'(e.y));
                check("C_out", 32'(bus.C_out), 32'(e.c));
                check("done_cycle", 32'(cyc), 32'(e.at));
                check("busy_at_done", 32'(bus.busy), 32'd1);
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy !== 1'b0) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%b, expected 0 within 200 cycles", bus.busy);
        end
    endtask

    task automatic scramble();
        bus.A      = 16'($urandom);
        bus.op     = 2'($urandom);
        bus.amount = 4'($urandom);
        bus.C_in   = 1'($urandom);
    endtask

    task automatic issue(input logic [15:0] a, input logic [1:0] op, input int k, input logic cin);
        wait_idle();
        bus.start  = 1'b1;
        bus.A      = a;
        bus.op     = op;
        bus.amount = k[3:0];
        bus.C_in   = cin;
        q.push_back(model(a, op, k, cin, cyc));
        @(negedge clk);
        bus.start = 1'b0;
        scramble();
    endtask

    initial begin
        int n;
        int s2;
        bus.start  = 1'b0;
        bus.A      = '0;
        bus.op     = '0;
        bus.amount = '0;
        bus.C_in   = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_Y", 32'(bus.Y), 32'h0);
        check("reset_C_out", 32'(bus.C_out), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(16'h8001, 2'b01, 1, 1'b0);
        check("busy_after_start", 32'(bus.busy), 32'h1);
        issue(16'h8001, 2'b10, 4, 1'b0);
        issue(16'h8000, 2'b11, 1, 1'b0);
        issue(16'h8000, 2'b11, 2, 1'b0);
        issue(16'hFFFF, 2'b01, 15, 1'b0);
        issue(16'h1234, 2'b00, 7, 1'b1);
        issue(16'h1234, 2'b01, 0, 1'b1);
        issue(16'hA5C3, 2'b11, 15, 1'b1);
        issue(16'h4001, 2'b10, 15, 1'b1);

        // A second start while shifting must be ignored.
        issue(16'h00F0, 2'b10, 8, 1'b0);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.A      = 16'hFFFF;
        bus.op     = 2'b11;
        bus.amount = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;

        // start held high: the next operation loads on the first IDLE edge after DONE.
        wait_idle();
        bus.start  = 1'b1;
        bus.A      = 16'h0F0F;
        bus.op     = 2'b01;
        bus.amount = 4'd5;
        bus.C_in   = 1'b0;
        q.push_back(model(16'h0F0F, 2'b01, 5, 1'b0, cyc));
        @(negedge clk);
        n = 0;
        while (bus.done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.A      = 16'h8421;
        bus.op     = 2'b11;
        bus.amount = 4'd3;
        bus.C_in   = 1'b1;
        s2 = cyc + 1;
        q.push_back(model(16'h8421, 2'b11, 3, 1'b1, s2));
        repeat (2) @(negedge clk);
        bus.start = 1'b0;
        scramble();

        // Reset mid-SHIFT aborts the operation with no done pulse.
        issue(16'hFFFF, 2'b01, 10, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        check("midreset_Y", 32'(bus.Y), 32'h0);
        check("midreset_C_out", 32'(bus.C_out), 32'h0);
        check("midreset_busy", 32'(bus.busy), 32'h0);
        check("midreset_done", 32'(bus.done), 32'h0);
        repeat (15) @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            issue(16'($urandom), 2'($urandom_range(0, 3)), int'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end

        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (q.size() > 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", q.size());
        end
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
